// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider for DIV/DIVU/REM/REMU. It uses restoring
// division and produces one quotient bit per cycle. The result leaves as a
// single-cycle register-file write-back.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_i, op_i[1:0]          request + op (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend_i, divisor_i       rs1 / rs2 operand values
//   reg_waddr_i[4:0]            rd of the divide instruction
//   flush_i                     abort any operation in flight
//   busy_o                      high whenever the unit is not idle
//   reg_we_o, reg_waddr_o,      write-back strobe, rd and result
//   reg_wdata_o
//
// Build option: define DIV_FASTPATH_EN so that divide-by-zero and signed
// overflow skip the iteration phase and complete one cycle after start.
module ex_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 5;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic            is_rem_q;
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] quo_q;      // dividend magnitude shifts out, quotient shifts in
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   rem_q;      // 33-bit partial remainder
    logic [CW-1:0]   cnt_q;
    logic            quo_neg_q;
    logic            rem_neg_q;
    logic            spec_q;     // divide-by-zero or overflow: result is fixed
    logic [XLEN-1:0] spec_val_q;

    // Operand preparation for the start cycle.
    logic            signed_op_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic            div_zero_c;
    logic            ovf_c;
    logic [XLEN-1:0] spec_val_c;

    always_comb begin
        signed_op_c = ~op_i[0];
        a_neg_c     = signed_op_c & dividend_i[XLEN-1];
        b_neg_c     = signed_op_c & divisor_i[XLEN-1];
        a_mag_c     = a_neg_c ? -dividend_i : dividend_i;
        b_mag_c     = b_neg_c ? -divisor_i  : divisor_i;
        div_zero_c  = (divisor_i == '0);
        ovf_c       = signed_op_c & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF);
        if (div_zero_c)
            spec_val_c = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
        else
            spec_val_c = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end

    // One restoring-division step.
    logic [XLEN+1:0] shift_c;
    logic [XLEN+1:0] trial_c;
    logic            ge_c;
    logic [XLEN:0]   rem_nxt_c;
    logic [XLEN-1:0] quo_nxt_c;
    logic [XLEN-1:0] result_c;

    always_comb begin
        shift_c   = {rem_q, quo_q[XLEN-1]};
        trial_c   = shift_c - {2'b00, dsr_q};
        ge_c      = ~trial_c[XLEN+1];
        rem_nxt_c = ge_c ? trial_c[XLEN:0] : shift_c[XLEN:0];
        quo_nxt_c = {quo_q[XLEN-2:0], ge_c};
        if (spec_q)
            result_c = spec_val_q;
        else if (is_rem_q)
            result_c = rem_neg_q ? -rem_nxt_c[XLEN-1:0] : rem_nxt_c[XLEN-1:0];
        else
            result_c = quo_neg_q ? -quo_nxt_c : quo_nxt_c;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_rem_q    <= 1'b0;
            rd_q        <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            spec_q      <= 1'b0;
            spec_val_q  <= '0;
            busy_o      <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            reg_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        is_rem_q   <= op_i[1];
                        rd_q       <= reg_waddr_i;
                        quo_q      <= a_mag_c;
                        dsr_q      <= b_mag_c;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        quo_neg_q  <= a_neg_c ^ b_neg_c;
                        rem_neg_q  <= a_neg_c;
                        spec_q     <= div_zero_c | ovf_c;
                        spec_val_q <= spec_val_c;
                        busy_o     <= 1'b1;
`ifdef DIV_FASTPATH_EN
                        if (div_zero_c || ovf_c) begin
                            state       <= DONE;
                            reg_we_o    <= 1'b1;
                            reg_waddr_o <= reg_waddr_i;
                            reg_wdata_o <= spec_val_c;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem_q <= rem_nxt_c;
                        quo_q <= quo_nxt_c;
                        cnt_q <= cnt_q + CW'(1);
                        // Last of 32 iterations: the counter wraps as the result is registered.
                        if (cnt_q == CW'(31)) begin
                            state       <= DONE;
                            reg_we_o    <= 1'b1;
                            reg_waddr_o <= rd_q;
                            reg_wdata_o <= result_c;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases, randomized operands checked
// against an arithmetic reference, and flush, start-while-busy and reset cases.
module tb_ex_div;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks   = 0;
    int failures = 0;

    ex_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .reg_we_o   (reg_we_o),
        .reg_waddr_o(reg_waddr_o),
        .reg_wdata_o(reg_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the RV32M arithmetic rules.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide (start high in cycle 0) and watch cycles 1..36.
    // poke > 0 pulses start_i with unrelated operands in that cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int poke);
        logic [31:0] exp;
        logic [31:0] got_d;
        logic [4:0]  got_a;
        int exp_lat;
        int we_cnt;
        int we_cyc;
        int busy_cnt;
        int busy_last;
        exp       = ref_div(op, a, b);
        exp_lat   = ref_lat(op, a, b);
        we_cnt    = 0;
        we_cyc    = -1;
        busy_cnt  = 0;
        busy_last = 0;
        got_d     = 'x;
        got_a     = 'x;
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        @(negedge clk);
        start_i = 1'b0; op_i = 2'($urandom); dividend_i = $urandom; divisor_i = $urandom;
        reg_waddr_i = 5'($urandom);
        for (int cyc = 1; cyc <= 36; cyc++) begin
            if (busy_o) begin busy_cnt++; busy_last = cyc; end
            if (reg_we_o) begin we_cnt++; we_cyc = cyc; got_d = reg_wdata_o; got_a = reg_waddr_o; end
            start_i = (cyc == poke);
            @(negedge clk);
        end
        start_i = 1'b0;
        check("we_count",    32'(we_cnt),    32'd1);
        check("we_cycle",    32'(we_cyc),    32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt),  32'(exp_lat));
        check("busy_last",   32'(busy_last), 32'(exp_lat));
        check("wdata",       got_d,          exp);
        check("waddr",       32'(got_a),     32'(rd));
    endtask

    initial begin
        int we_cnt;
        int we_cyc;
        logic [31:0] got_d;
        logic [4:0]  got_a;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
        reg_waddr_i = '0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_we",    32'(reg_we_o),    32'd0);
        check("rst_waddr", 32'(reg_waddr_o), 32'd0);
        check("rst_wdata", reg_wdata_o,      32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(2'b01, 32'd100, 32'd7, 5'd5, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd3, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
        run_op(2'b00, 32'd1234, 32'd0, 5'd7, 0);
        run_op(2'b11, 32'd1234, 32'd0, 5'd0, 0);
        run_op(2'b10, 32'hFFFF_FB2E, 32'd0, 5'd8, 0);
        run_op(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd31, 0);
        // Start pulse while busy must be ignored.
        run_op(2'b01, 32'd5000, 32'd9, 5'd10, 5);

        // Randomized operands with edge-value bias.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 5'($urandom), 0);
        end

        // Flush in cycle 10 of a DIVU, new DIV started in cycle 11.
        we_cnt = 0; we_cyc = -1; got_d = 'x; got_a = 'x;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd9;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (reg_we_o) begin we_cnt++; we_cyc = cyc; got_d = reg_wdata_o; got_a = reg_waddr_o; end
            if (cyc == 10) check("flush_busy_before", 32'(busy_o), 32'd1);
            if (cyc == 11) check("flush_idle_after",  32'(busy_o), 32'd0);
            flush_i = (cyc == 10);
            if (cyc == 11) begin
                start_i = 1'b1; op_i = 2'b00; dividend_i = 32'hFFFF_FFCE; divisor_i = 32'd7; reg_waddr_i = 5'd12;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        flush_i = 1'b0;
        check("flush_we_count", 32'(we_cnt), 32'd1);
        check("flush_we_cycle", 32'(we_cyc), 32'd44);
        check("flush_wdata",    got_d,       ref_div(2'b00, 32'hFFFF_FFCE, 32'd7));
        check("flush_waddr",    32'(got_a),  32'd12);

        // Asynchronous reset in cycle 20 of a divide.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd77777; divisor_i = 32'd13; reg_waddr_i = 5'd21;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy_o),      32'd0);
        check("arst_we",    32'(reg_we_o),    32'd0);
        check("arst_waddr", 32'(reg_waddr_o), 32'd0);
        check("arst_wdata", reg_wdata_o,      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (reg_we_o) we_cnt++;
            @(negedge clk);
        end
        check("post_rst_we_count", 32'(we_cnt), 32'd0);
        check("post_rst_busy",     32'(busy_o), 32'd0);

        // Unit still works after the reset.
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd17, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
